// File: rtl/cbus_timer_irq_if.sv
// Common-bus slave port of the timer: request/acknowledge handshake with
// byte strobes (wstrb == 0 is a read) and read-data return.
interface cbus_timer_irq_if;
  logic        timer_valid;
  logic        timer_ready;
  logic [3:0]  timer_wstrb;
  logic [31:0] timer_addr;
  logic [31:0] timer_wdata;
  logic [31:0] timer_rdata;

  modport master (
    output timer_valid, timer_wstrb, timer_addr, timer_wdata,
    input  timer_ready, timer_rdata
  );

  modport slave (
    input  timer_valid, timer_wstrb, timer_addr, timer_wdata,
    output timer_ready, timer_rdata
  );
endinterface

// File: rtl/cbus_timer_irq.sv
// Memory-mapped 32-bit timer: prescaler, compare match with optional
// auto-reload, sticky MATCH flag and registered level interrupt.
// Bus accesses take two cycles: request sampled in IDLE, one-cycle ACK
// during which ready is high and the write is committed at its end.
module cbus_timer_irq #(
  parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  cbus_timer_irq_if.slave  bus,
  output logic             irq_out,
  input  logic             eoi_in
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  localparam logic [5:0] R_CTRL     = 6'd0;
  localparam logic [5:0] R_PRESCALE = 6'd1;
  localparam logic [5:0] R_COMPARE  = 6'd2;
  localparam logic [5:0] R_COUNT    = 6'd3;
  localparam logic [5:0] R_STATUS   = 6'd4;

  state_t                state_q, state_d;
  logic [5:0]            op_idx_q, op_idx_d;
  logic [3:0]            op_strb_q, op_strb_d;
  logic [31:0]           op_wdata_q, op_wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           count_q, count_d;
  logic                  match_q, match_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  irq_q, irq_d;

  logic [7:0]            req_off;
  logic                  wr_en;
  logic                  tick;
  logic                  match_set;
  logic                  match_clr;
  logic [31:0]           cur_val;
  logic [31:0]           wr_merged;

  // BASE_ADDR is 256-byte aligned, so this reduces to addr[7:0].
  assign req_off = bus.timer_addr[7:0] - BASE_ADDR[7:0];

  function automatic logic [31:0] reg_read(input logic [5:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      R_CTRL:     v = {29'd0, ctrl_q};
      R_PRESCALE: v = 32'(prescale_q);
      R_COMPARE:  v = compare_q;
      R_COUNT:    v = count_q;
      R_STATUS:   v = {31'd0, match_q};
      default:    v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] v;
    v = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
    end
    return v;
  endfunction

  // Bus FSM next state; latches the request and snapshots read data in IDLE.
  always_comb begin
    state_d    = state_q;
    op_idx_d   = op_idx_q;
    op_strb_d  = op_strb_q;
    op_wdata_d = op_wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.timer_valid) begin
          state_d    = S_ACK;
          op_idx_d   = req_off[7:2];
          op_strb_d  = bus.timer_wstrb;
          op_wdata_d = bus.timer_wdata;
          rdata_d    = reg_read(req_off[7:2]);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus FSM state and latched-request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op_idx_q   <= '0;
      op_strb_q  <= '0;
      op_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_idx_q   <= op_idx_d;
      op_strb_q  <= op_strb_d;
      op_wdata_q <= op_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.timer_ready = (state_q == S_ACK);
  assign bus.timer_rdata = rdata_q;
  assign irq_out         = irq_q;

  assign wr_en     = (state_q == S_ACK) && (op_strb_q != 4'd0);
  assign tick      = ctrl_q[0] && (pcnt_q == prescale_q);
  assign cur_val   = reg_read(op_idx_q);
  assign wr_merged = merge_bytes(cur_val, op_wdata_q, op_strb_q);

  // Timer datapath: tick-driven updates first, then bus writes override,
  // then MATCH set wins over any clear in the same cycle.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    pcnt_d     = pcnt_q;
    match_set  = 1'b0;
    match_clr  = eoi_in;

    if (!ctrl_q[0] || tick) pcnt_d = '0;
    else                    pcnt_d = pcnt_q + PRESCALE_W'(1);

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[1] ? '0 : count_q + 32'd1;
      end else begin
        count_d   = count_q + 32'd1;
      end
    end

    if (wr_en) begin
      case (op_idx_q)
        R_CTRL:     ctrl_d = wr_merged[2:0];
        R_PRESCALE: begin
          prescale_d = wr_merged[PRESCALE_W-1:0];
          pcnt_d     = '0;
        end
        R_COMPARE:  compare_d = wr_merged;
        R_COUNT: begin
          count_d = wr_merged;
          pcnt_d  = '0;
        end
        R_STATUS: begin
          if (op_strb_q[0] && op_wdata_q[0]) match_clr = 1'b1;
        end
        default: ;
      endcase
    end

    if (match_set)      match_d = 1'b1;
    else if (match_clr) match_d = 1'b0;
    else                match_d = match_q;

    irq_d = match_q && ctrl_q[2];
  end

  // Timer register state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      match_q    <= 1'b0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      match_q    <= match_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_cbus_timer_irq.sv
// Directed bench for cbus_timer_irq: reset, bus handshake, periodic and
// one-shot counting, EOI/match race and write/tick collision.
module tb_cbus_timer_irq;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic clk;
  logic resetn;
  logic irq_out;
  logic eoi_in;

  int unsigned applied;
  int unsigned miscompares;

  cbus_timer_irq_if bus ();

  cbus_timer_irq #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .irq_out (irq_out),
    .eoi_in  (eoi_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One transaction: drive after edge A, sampled at A+1, ACK cycle, commit at A+2.
  task automatic xfer(input logic [7:0] off, input logic [3:0] strb,
                      input logic [31:0] wd, output logic [31:0] rd);
    @(posedge clk); #1;
    bus.timer_valid = 1'b1;
    bus.timer_addr  = BASE | {24'd0, off};
    bus.timer_wstrb = strb;
    bus.timer_wdata = wd;
    chk("ready_pre", {31'd0, bus.timer_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_hi", {31'd0, bus.timer_ready}, 32'd1);
    rd = bus.timer_rdata;
    bus.timer_valid = 1'b0;
    bus.timer_wstrb = 4'd0;
    @(posedge clk); #1;
    chk("ready_lo", {31'd0, bus.timer_ready}, 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(off, strb, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    xfer(off, 4'd0, 32'hDEAD_BEEF, v);
    chk(tag, v, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    chk(tag, {31'd0, irq_out}, {31'd0, exp});
  endtask

  initial begin
    applied         = 0;
    miscompares     = 0;
    resetn          = 1'b0;
    eoi_in          = 1'b0;
    bus.timer_valid = 1'b0;
    bus.timer_wstrb = 4'd0;
    bus.timer_addr  = '0;
    bus.timer_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.timer_ready}, 32'd0);
    chk("rst_rdata", bus.timer_rdata, 32'd0);
    irq_chk("rst_irq", 1'b0);
    resetn = 1'b1;

    // Reset during ACK: no ready, no write committed
    @(posedge clk); #1;
    bus.timer_valid = 1'b1;
    bus.timer_addr  = BASE | 32'h00;
    bus.timer_wstrb = 4'hF;
    bus.timer_wdata = 32'h7;
    @(posedge clk); #1;
    chk("mid_ready_hi", {31'd0, bus.timer_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_ready_rst", {31'd0, bus.timer_ready}, 32'd0);
    irq_chk("mid_irq_rst", 1'b0);
    bus.timer_valid = 1'b0;
    bus.timer_wstrb = 4'd0;
    @(posedge clk); #1;
    resetn = 1'b1;
    rd_chk("rst_ctrl",     8'h00, 32'd0);
    rd_chk("rst_prescale", 8'h04, 32'd0);
    rd_chk("rst_compare",  8'h08, 32'd0);
    rd_chk("rst_count",    8'h0C, 32'd0);
    rd_chk("rst_status",   8'h10, 32'd0);
    rd_chk("rst_unmapped", 8'h14, 32'd0);

    // Byte strobes
    wr(8'h08, 4'b0011, 32'h1234_5678);
    rd_chk("cmp_strobe", 8'h08, 32'h0000_5678);
    wr(8'h14, 4'hF, 32'hFFFF_FFFF);
    rd_chk("unmapped_wr", 8'h14, 32'd0);

    // Periodic: CTRL commit at E; matches at E+20, E+40, E+60
    wr(8'h04, 4'hF, 32'd3);
    wr(8'h08, 4'hF, 32'd4);
    wr(8'h00, 4'hF, 32'h7);
    repeat (20) @(posedge clk);
    #1 irq_chk("per_irq_e20", 1'b0);
    @(posedge clk); #1;
    irq_chk("per_irq_e21", 1'b1);
    rd_chk("per_count_reload", 8'h0C, 32'd0);
    rd_chk("per_status", 8'h10, 32'd1);
    eoi_in = 1'b1;
    @(posedge clk); #1;
    eoi_in = 1'b0;
    irq_chk("per_eoi_c", 1'b1);
    @(posedge clk); #1;
    irq_chk("per_eoi_c1", 1'b0);
    repeat (11) @(posedge clk);
    #1 irq_chk("per_irq_e40", 1'b0);
    @(posedge clk); #1;
    irq_chk("per_irq_e41", 1'b1);

    // EOI in the same cycle as the E+60 match
    repeat (18) @(posedge clk);
    #1 eoi_in = 1'b1;
    @(posedge clk); #1;
    eoi_in = 1'b0;
    irq_chk("race_e60", 1'b1);
    @(posedge clk); #1;
    irq_chk("race_e61", 1'b1);
    eoi_in = 1'b1;
    @(posedge clk); #1;
    eoi_in = 1'b0;
    irq_chk("eoi_alone_c", 1'b1);
    @(posedge clk); #1;
    irq_chk("eoi_alone_c1", 1'b0);
    rd_chk("eoi_status", 8'h10, 32'd0);
    wr(8'h00, 4'hF, 32'h0);

    // One-shot wrap: tick every cycle, match at 8th tick
    wr(8'h04, 4'hF, 32'd0);
    wr(8'h08, 4'hF, 32'd5);
    wr(8'h0C, 4'hF, 32'hFFFF_FFFE);
    wr(8'h00, 4'hF, 32'h5);
    @(posedge clk); #1;
    rd_chk("wrap_count0", 8'h0C, 32'd0);
    repeat (4) @(posedge clk);
    #1 irq_chk("wrap_irq_e8", 1'b0);
    @(posedge clk); #1;
    irq_chk("wrap_irq_e9", 1'b1);
    rd_chk("wrap_count_e10", 8'h0C, 32'd8);
    rd_chk("wrap_status", 8'h10, 32'd1);
    wr(8'h00, 4'hF, 32'h0);
    wr(8'h10, 4'b0010, 32'h1);
    rd_chk("w1c_nostrb", 8'h10, 32'd1);
    wr(8'h10, 4'b0001, 32'h1);
    rd_chk("w1c_clear", 8'h10, 32'd0);

    // Write/tick collision with PRESCALE=0
    wr(8'h08, 4'hF, 32'hFFFF_0000);
    wr(8'h00, 4'hF, 32'h1);
    wr(8'h0C, 4'hF, 32'h0000_0100);
    rd_chk("coll_count", 8'h0C, 32'h0000_0101);
    wr(8'h00, 4'hF, 32'h0);
    rd_chk("coll_stop", 8'h0C, 32'h0000_0106);
    wr(8'h0C, 4'b1010, 32'hAABB_CCDD);
    rd_chk("count_strobe", 8'h0C, 32'hAA00_CC06);
    rd_chk("ctrl_final", 8'h00, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cbus_timer_irq.md
# cbus_timer_irq

Memory-mapped 32-bit timer with prescaler, compare match and a level interrupt output. It sits on the SoC common bus as a peer of the SRAM, sensor, IO and UART bridges, decoded at 0x50000000–0x500000FF. It drives one bit of the CPU `irq` vector and consumes the matching `eoi` bit. Firmware uses it for periodic control-loop ticks and for timeouts.

## Interface
- `BASE_ADDR`, 32'h50000000: bus base. Only `addr[7:2]` are decoded inside the block; the parent does range selection.
- `PRESCALE_W`, 16: width of the prescaler register and counter.
- `clk`  in  1: system clock.
- `resetn`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `timer_valid`  in  1: bus request. Already gated to this block's address range.
- `timer_ready`  out  1: transaction-complete pulse.
- `timer_wstrb`  in  4: byte write strobes. 0 means read.
- `timer_addr`  in  32: byte address.
- `timer_wdata`  in  32: write data.
- `timer_rdata`  out  32: read data, valid while `timer_ready` is high.
- `irq_out`  out  1: level interrupt to the CPU.
- `eoi_in`  in  1: end-of-interrupt from the CPU, sampled each cycle.

## Operation
- Register map at offset = `addr[7:0]`:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 0x04 PRESCALE: bits [PRESCALE_W-1:0].
  - 0x08 COMPARE: bits [31:0].
  - 0x0C COUNT: bits [31:0], read/write.
  - 0x10 STATUS: bit0 MATCH, sticky. Writing 1 to bit0 (with `wstrb[0]` set) clears it.
  - Other offsets: read 0, writes ignored.
- Writes honour byte strobes; unstrobed bytes are unchanged. Reads ignore `wstrb`.
- Prescaler:
  - `pcnt` counts 0..PRESCALE while EN=1.
  - `tick` = EN && (`pcnt` == PRESCALE). On tick, `pcnt` returns to 0. PRESCALE=0 gives a tick every cycle.
  - EN=0 holds `pcnt` at 0 and suppresses ticks.
- Counter, updated on tick only:
  - If COUNT == COMPARE: set MATCH. COUNT becomes 0 if AUTO_RELOAD, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1 mod 2^32, so 0xFFFFFFFF wraps to 0.
- `irq_out` is a register equal to MATCH && IRQ_EN, delayed one cycle.
- Clearing MATCH: either an `eoi_in` high cycle or a STATUS W1C write.
- Priority within one cycle:
  - MATCH set beats MATCH clear (from eoi or W1C).
  - A bus write to COUNT beats a tick increment, and the same write forces `pcnt` to 0.
  - A bus write to PRESCALE forces `pcnt` to 0.
  - A bus write to CTRL takes effect for the tick decision from the next cycle.
- Bus FSM states: IDLE, ACK.
  - IDLE: if `timer_valid`, latch the operation and go to ACK. Read data is captured at this edge.
  - ACK: drive `timer_ready`=1 for exactly one cycle and commit the write at the end of this cycle, then return to IDLE regardless of `timer_valid`.
  - A still-high `timer_valid` in IDLE after ACK starts a new transaction, which is legal for back-to-back access.
- Reset mid-transaction aborts it with no write committed and no ready pulse.

## Timing
- Reset values: every output is 0 (`timer_ready`=0, `timer_rdata`=0, `irq_out`=0). All registers, `pcnt` and the FSM (IDLE) are cleared.
- Bus latency: `timer_valid` sampled high at edge N gives `timer_ready`=1 and valid `timer_rdata` in cycle N+1. `timer_ready` is 0 in cycle N+2. The minimum transaction spacing is 2 cycles.
- Write visibility: a write committed at the end of the ACK cycle is readable by the next transaction.
- Tick spacing: PRESCALE+1 cycles between ticks.
- Match to IRQ:
  - A MATCH set at edge T is visible in STATUS from cycle T.
  - `irq_out` goes high at edge T+1.
  - After a clear at edge C, `irq_out` goes low at edge C+1.
- `timer_rdata` holds its value outside ready cycles; its value is don't-care to the master.

## Test plan
- Reset: assert `resetn`=0 mid-transaction → `timer_ready`=0 and `irq_out`=0. After release, a read of every register returns 0.
- Bus: write 0x12345678 with wstrb=4'b0011 to COMPARE, then read it → 0x00005678. `timer_ready` is high exactly 1 cycle, 1 cycle after valid.
- Periodic:
  - Setup: PRESCALE=3, COMPARE=4, CTRL=0b111.
  - Expected: MATCH sets 20 cycles after EN, COUNT goes back to 0, `irq_out` rises 1 cycle later.
  - Repeat: the next match comes exactly 20 cycles after that.
- One-shot wrap: COUNT=0xFFFFFFFE, COMPARE=0x5, PRESCALE=0, CTRL=0b101 → COUNT reads 0x0 after 2 ticks and MATCH sets at the 8th tick with COUNT→6.
- EOI race: pulse `eoi_in` in the same cycle as a new match → MATCH stays 1 and `irq_out` stays high. A later `eoi_in` alone → `irq_out` low 1 cycle later.
- Write/tick collision: write COUNT=0x100 on a tick cycle with PRESCALE=0 → COUNT reads 0x100 and the next tick gives 0x101.
